// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer for a UART. The byte-complete indication from the receiver is treated as a
// level, so its rising edge is turned into a single write request. Bytes are held in a
// 2^ADDR_WIDTH deep circular buffer. They are handed to the consumer one at a time, through a
// registered output that has one cycle of latency. A byte that arrives while the buffer is full,
// with no read freeing a slot in the same cycle, is dropped and recorded in a sticky overflow flag.
//
// Parameters
//   DATA_BIT_NUM  width of one stored byte
//   ADDR_WIDTH    log2 of the FIFO depth
//
// Ports
//   clk           clock; every flop is on its rising edge
//   reset         asynchronous, active-high reset
//   rx_data       received byte, stable while rx_done is high
//   rx_done       byte-complete level from the UART receiver
//   rd_en         consumer read request, ignored while empty
//   clr_overflow  clears the sticky overflow flag
//   dout          registered read data, holds between reads
//   dout_valid    one-cycle pulse marking new data on dout
//   empty         FIFO holds no entries
//   full          FIFO holds 2^ADDR_WIDTH entries
//   count         current occupancy, 0 .. 2^ADDR_WIDTH
//   overflow      sticky: at least one byte was dropped
// ---------------------------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned DATA_BIT_NUM = 8,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_BIT_NUM-1:0] rx_data,
    input  logic                    rx_done,
    input  logic                    rd_en,
    input  logic                    clr_overflow,
    output logic [DATA_BIT_NUM-1:0] dout,
    output logic                    dout_valid,
    output logic                    empty,
    output logic                    full,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    overflow
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    // Occupancy value that means "every slot used".
    localparam logic [ADDR_WIDTH:0] FullCount = {1'b1, {ADDR_WIDTH{1'b0}}};

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [DATA_BIT_NUM-1:0] mem_q [Depth];

    logic                    rx_done_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q,      count_d;
    logic                    overflow_q,   overflow_d;
    logic [DATA_BIT_NUM-1:0] dout_q,       dout_d;
    logic                    dout_valid_q, dout_valid_d;

    // -----------------------------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------------------------
    logic empty_s;
    logic full_s;
    logic wr_req;
    logic rd_accept;
    logic wr_accept;
    logic wr_drop;

    // Flags come straight from the registered count, so they have no input-to-output path.
    assign empty_s = (count_q == '0);
    assign full_s  = (count_q == FullCount);

    // One write per rising edge of the level-type done signal. rx_done_q resets low, so a done
    // level already high when reset releases still produces one write.
    assign wr_req = rx_done & ~rx_done_q;

    assign rd_accept = rd_en & ~empty_s;

    // When full, a same-cycle read frees the slot the write lands in.
    assign wr_accept = wr_req & (~full_s | rd_accept);
    assign wr_drop   = wr_req & full_s & ~rd_accept;

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        // Pointers are exactly ADDR_WIDTH bits wide, so the increment wraps naturally.
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (rd_accept) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            dout_d       = mem_q[rd_ptr_q];
            dout_valid_d = 1'b1;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            rx_done_q    <= rx_done;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Storage is not reset; stale contents are unreachable because the pointers and count are.
    // On a full-plus-read cycle both pointers address the same slot. The read samples the old
    // byte before this write replaces it.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign empty      = empty_s;
    assign full       = full_s;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rd_en;
    logic       clr_overflow;
    logic [7:0] dout;
    logic       dout_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int n_cmp;
    int n_err;

    uart_rx_fifo #(
        .DATA_BIT_NUM(8),
        .ADDR_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rd_en       (rd_en),
        .clr_overflow(clr_overflow),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", dout); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        push(8'hA5);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL basic_cnt1 got %0d want 1", count); end
        push(8'h3C);
        n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL basic_cnt2 got %0d want 2", count); end
        pop();
        n_cmp++; if (dout !== 8'hA5 || dout_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd1 got %h/%b want a5/1", dout, dout_valid); end
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL basic_cnt3 got %0d want 1", count); end
        tick();
        n_cmp++; if (dout_valid !== 1'b0 || dout !== 8'hA5) begin n_err++; $display("FAIL basic_pulse got %h/%b want a5/0", dout, dout_valid); end
        pop();
        n_cmp++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd2 got %h/%b want 3c/1", dout, dout_valid); end
        n_cmp++; if (count !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL basic_end got %0d/%b want 0/1", count, empty); end
        tick();
    endtask

    task automatic test_level();
        rx_data = 8'h55;
        rx_done = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rx_done = 1'b0;
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL level_cnt got %0d want 1", count); end
        tick();
        pop();
        n_cmp++; if (dout !== 8'h55 || dout_valid !== 1'b1) begin n_err++; $display("FAIL level_rd got %h/%b want 55/1", dout, dout_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL level_empty got %b want 1", empty); end
        tick();
    endtask

    task automatic test_full_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) push(8'(i));
        n_cmp++; if (full !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL fill got full=%b cnt=%0d want 1/16", full, count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf got %b want 0", overflow); end
        push(8'hFF);
        n_cmp++; if (overflow !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL drop got ovf=%b cnt=%0d want 1/16", overflow, count); end
        // Clear and a fresh drop in the same cycle: the drop wins.
        rx_data = 8'hEE; rx_done = 1'b1; clr_overflow = 1'b1;
        tick();
        rx_done = 1'b0; clr_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL setwins got %b want 1", overflow); end
        tick();
        for (int i = 0; i < 16; i++) begin
            exp = 8'(i);
            pop();
            n_cmp++; if (dout !== exp || dout_valid !== 1'b1) begin n_err++; $display("FAIL order_%0d got %h/%b want %h/1", i, dout, dout_valid, exp); end
        end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL drain got empty=%b full=%b want 1/0", empty, full); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sticky got %b want 1", overflow); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr got %b want 0", overflow); end
        tick();
    endtask

    task automatic test_full_simul();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        rx_data = 8'hAA; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        n_cmp++; if (dout !== 8'h10 || dout_valid !== 1'b1) begin n_err++; $display("FAIL fsim_rd got %h/%b want 10/1", dout, dout_valid); end
        n_cmp++; if (count !== 5'd16 || overflow !== 1'b0) begin n_err++; $display("FAIL fsim_cnt got cnt=%0d ovf=%b want 16/0", count, overflow); end
        tick();
        for (int i = 1; i < 17; i++) begin
            exp = (i == 16) ? 8'hAA : 8'(8'h10 + i);
            pop();
            n_cmp++; if (dout !== exp) begin n_err++; $display("FAIL fsim_order_%0d got %h want %h", i, dout, exp); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fsim_empty got %b want 1", empty); end
        tick();
    endtask

    task automatic test_empty_simul();
        rx_data = 8'h81; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        n_cmp++; if (dout_valid !== 1'b0 || dout !== 8'hAA) begin n_err++; $display("FAIL esim_rd got %h/%b want aa/0", dout, dout_valid); end
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL esim_cnt got %0d want 1", count); end
        tick();
        pop();
        n_cmp++; if (dout !== 8'h81 || dout_valid !== 1'b1) begin n_err++; $display("FAIL esim_next got %h/%b want 81/1", dout, dout_valid); end
        tick();
    endtask

    task automatic test_wrap_reset();
        logic [7:0] exp;
        for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 10; i++) begin
            exp = 8'(8'h20 + i);
            pop();
            n_cmp++; if (dout !== exp) begin n_err++; $display("FAIL wrap_a_%0d got %h want %h", i, dout, exp); end
        end
        for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
        n_cmp++; if (count !== 5'd10 || full !== 1'b0 || empty !== 1'b0) begin n_err++; $display("FAIL wrap_cnt got %0d f=%b e=%b want 10/0/0", count, full, empty); end
        // Read across the pointer wrap point (slots 15 -> 0).
        for (int i = 0; i < 8; i++) begin
            exp = 8'(8'h40 + i);
            pop();
            n_cmp++; if (dout !== exp) begin n_err++; $display("FAIL wrap_b_%0d got %h want %h", i, dout, exp); end
        end
        // Reset mid-stream, between clock edges, with rx_done high across the release.
        rx_data = 8'h42; rx_done = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL mrst_flags got %0d e=%b f=%b want 0/1/0", count, empty, full); end
        n_cmp++; if (overflow !== 1'b0 || dout !== 8'h00 || dout_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out got ovf=%b dout=%h v=%b want 0/00/0", overflow, dout, dout_valid); end
        tick();
        reset = 1'b0;
        tick();
        rx_done = 1'b0;
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL mrst_wr got %0d want 1", count); end
        tick();
        pop();
        n_cmp++; if (dout !== 8'h42 || dout_valid !== 1'b1) begin n_err++; $display("FAIL mrst_rd got %h/%b want 42/1", dout, dout_valid); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL mrst_empty got %b want 1", empty); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        rd_en = 1'b0;
        clr_overflow = 1'b0;
        test_reset();
        test_basic();
        test_level();
        test_full_overflow();
        test_full_simul();
        test_empty_simul();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
